multicycle_control_unit: RTL and testbench

//  Moore FSM control unit for the multicycle MIPS datapath (shared memory, IR, A/B, ALUOut registers).

---
 rtl/mc_ctrl_pkg.sv | 137 +++++++++++++
 rtl/mc_alu_decoder.sv | 34 +++
 rtl/multicycle_control_unit.sv | 123 ++++++++++++
 tb/tb_multicycle_control_unit.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared state, opcode and control-word definitions for the multicycle MIPS control unit.
// The control unit's optional bne/andi/ori support is enabled with MCU_EXT_OPS_EN.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11,
        IMMEX   = 4'd12
    } state_t;

    // ALUOP_AND doubles as the idle value so unused cycles drive alu_control=000
    typedef enum logic [2:0] {
        ALUOP_AND   = 3'd0,
        ALUOP_ADD   = 3'd1,
        ALUOP_SUB   = 3'd2,
        ALUOP_OR    = 3'd3,
        ALUOP_FUNCT = 3'd4
    } alu_op_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALUC_ADD = 3'b010;
    localparam logic [2:0] ALUC_SUB = 3'b110;
    localparam logic [2:0] ALUC_AND = 3'b000;
    localparam logic [2:0] ALUC_OR  = 3'b001;
    localparam logic [2:0] ALUC_SLT = 3'b111;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       fetch;
        logic       iord;
        logic       mem_write;
        logic       reg_dst;
        logic       memto_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        alu_op_t    alu_op;
        logic [1:0] pc_src;
        logic       pc_write;
        logic       branch;
    } ctrl_t;

    // Moore control word for a state; orSel picks or/and for the logical-immediate state
    function automatic ctrl_t state_ctrl(input state_t s, input logic orSel);
        ctrl_t c;
        c        = '0;
        c.alu_op = ALUOP_AND;
        case (s)
            FETCH: begin
                c.fetch     = 1'b1;
                c.alu_src_b = SRCB_FOUR;
                c.alu_op    = ALUOP_ADD;
                c.pc_src    = PCSRC_ALU;
            end
            DECODE: begin
                c.alu_src_b = SRCB_IMMSH;
                c.alu_op    = ALUOP_ADD;
            end
            MEMADR, ADDIEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_ADD;
            end
            MEMRD:   c.iord = 1'b1;
            MEMWB: begin
                c.reg_write = 1'b1;
                c.memto_reg = 1'b1;
            end
            MEMWR: begin
                c.iord      = 1'b1;
                c.mem_write = 1'b1;
            end
            EXECUTE: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_B;
                c.alu_op    = ALUOP_FUNCT;
            end
            ALUWB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            BRANCH: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_B;
                c.alu_op    = ALUOP_SUB;
                c.pc_src    = PCSRC_ALUOUT;
                c.branch    = 1'b1;
            end
            ADDIWB:  c.reg_write = 1'b1;
            JUMP: begin
                c.pc_src   = PCSRC_JUMP;
                c.pc_write = 1'b1;
            end
            IMMEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = orSel ? ALUOP_OR : ALUOP_AND;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// Combinational ALU-control decode: maps the FSM's ALU operation request and funct to alu_control.
module mc_alu_decoder
    import mc_ctrl_pkg::*;
#(
    parameter int FN_W       = 6,
    parameter int ALU_CTRL_W = 3
) (
    input  alu_op_t               alu_op_i,
    input  logic [FN_W-1:0]       funct_i,
    output logic [ALU_CTRL_W-1:0] alu_control_o
);

    // Unknown funct codes fall back to add so the write-back still gets a defined value
    always_comb begin
        alu_control_o = ALU_CTRL_W'(ALUC_AND);
        case (alu_op_i)
            ALUOP_ADD: alu_control_o = ALU_CTRL_W'(ALUC_ADD);
            ALUOP_SUB: alu_control_o = ALU_CTRL_W'(ALUC_SUB);
            ALUOP_OR:  alu_control_o = ALU_CTRL_W'(ALUC_OR);
            ALUOP_FUNCT: begin
                case (funct_i)
                    FN_W'(FN_ADD): alu_control_o = ALU_CTRL_W'(ALUC_ADD);
                    FN_W'(FN_SUB): alu_control_o = ALU_CTRL_W'(ALUC_SUB);
                    FN_W'(FN_AND): alu_control_o = ALU_CTRL_W'(ALUC_AND);
                    FN_W'(FN_OR):  alu_control_o = ALU_CTRL_W'(ALUC_OR);
                    FN_W'(FN_SLT): alu_control_o = ALU_CTRL_W'(ALUC_SLT);
                    default:       alu_control_o = ALU_CTRL_W'(ALUC_ADD);
                endcase
            end
            default: alu_control_o = ALU_CTRL_W'(ALUC_AND);
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore FSM control unit for the multicycle MIPS datapath with variable-latency memory.
// Define MCU_EXT_OPS_EN to add bne, andi and ori; otherwise those opcodes are illegal.
module multicycle_control_unit
    import mc_ctrl_pkg::*;
#(
    parameter int OP_W       = 6,
    parameter int FN_W       = 6,
    parameter int ALU_CTRL_W = 3,
    parameter int STATE_W    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [OP_W-1:0]       opcode,
    input  logic [FN_W-1:0]       funct,
    input  logic                  zero,
    input  logic                  mem_ready,
    output logic                  iord,
    output logic                  mem_write,
    output logic                  ir_write,
    output logic                  reg_dst,
    output logic                  memto_reg,
    output logic                  reg_write,
    output logic                  alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic [1:0]            pc_src,
    output logic                  pc_en,
    output logic                  ext_zero,
    output logic                  illegal_op,
    output logic [STATE_W-1:0]    state_o
);

    state_t                state_q, state_d;
    ctrl_t                 ctrl_q;
    logic                  isLw, isSw, isRtype, isBeq, isAddi, isJ;
    logic                  isBne, isLogicImm, legalOp, branchTaken, pcEnRaw;
    logic [ALU_CTRL_W-1:0] aluCtrl;

    assign isLw    = (opcode == OP_W'(OP_LW));
    assign isSw    = (opcode == OP_W'(OP_SW));
    assign isRtype = (opcode == OP_W'(OP_RTYPE));
    assign isBeq   = (opcode == OP_W'(OP_BEQ));
    assign isAddi  = (opcode == OP_W'(OP_ADDI));
    assign isJ     = (opcode == OP_W'(OP_J));

`ifdef MCU_EXT_OPS_EN
    assign isBne      = (opcode == OP_W'(OP_BNE));
    assign isLogicImm = (opcode == OP_W'(OP_ANDI)) || (opcode == OP_W'(OP_ORI));
`else
    assign isBne      = 1'b0;
    assign isLogicImm = 1'b0;
`endif

    assign legalOp = isLw | isSw | isRtype | isBeq | isBne | isAddi | isLogicImm | isJ;

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:   if (mem_ready) state_d = DECODE;
            DECODE: begin
                if (isLw || isSw)        state_d = MEMADR;
                else if (isRtype)        state_d = EXECUTE;
                else if (isBeq || isBne) state_d = BRANCH;
                else if (isAddi)         state_d = ADDIEX;
                else if (isLogicImm)     state_d = IMMEX;
                else if (isJ)            state_d = JUMP;
                else                     state_d = FETCH;
            end
            MEMADR:  state_d = isLw ? MEMRD : MEMWR;
            MEMRD:   if (mem_ready) state_d = MEMWB;
            MEMWR:   if (mem_ready) state_d = FETCH;
            EXECUTE: state_d = ALUWB;
            ADDIEX:  state_d = ADDIWB;
            IMMEX:   state_d = ADDIWB;
            default: state_d = FETCH;
        endcase
    end

    // The control word is registered alongside the state so it always matches state_q
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FETCH;
            ctrl_q  <= state_ctrl(FETCH, 1'b0);
        end else begin
            state_q <= state_d;
            ctrl_q  <= state_ctrl(state_d, opcode[0]);
        end
    end

    mc_alu_decoder #(
        .FN_W       (FN_W),
        .ALU_CTRL_W (ALU_CTRL_W)
    ) u_aluDecoder (
        .alu_op_i      (ctrl_q.alu_op),
        .funct_i       (funct),
        .alu_control_o (aluCtrl)
    );

    assign branchTaken = isBne ? ~zero : zero;
    assign pcEnRaw     = ctrl_q.pc_write | (ctrl_q.fetch & mem_ready) | (ctrl_q.branch & branchTaken);

    // Holding reset silences every output, so an interrupted instruction issues no writes
    assign iord        = rst_n & ctrl_q.iord;
    assign mem_write   = rst_n & ctrl_q.mem_write;
    assign ir_write    = rst_n & ctrl_q.fetch & mem_ready;
    assign reg_dst     = rst_n & ctrl_q.reg_dst;
    assign memto_reg   = rst_n & ctrl_q.memto_reg;
    assign reg_write   = rst_n & ctrl_q.reg_write;
    assign alu_src_a   = rst_n & ctrl_q.alu_src_a;
    assign alu_src_b   = rst_n ? ctrl_q.alu_src_b : 2'b00;
    assign alu_control = rst_n ? aluCtrl : '0;
    assign pc_src      = rst_n ? ctrl_q.pc_src : 2'b00;
    assign pc_en       = rst_n & pcEnRaw;
    assign illegal_op  = rst_n & (state_q == DECODE) & ~legalOp;
    assign state_o     = rst_n ? STATE_W'(state_q) : '0;

`ifdef MCU_EXT_OPS_EN
    assign ext_zero = rst_n & (state_q == IMMEX);
`else
    assign ext_zero = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: directed instruction cases plus randomized programs.
// Honours MCU_EXT_OPS_EN the same way as the design.
module tb_multicycle_control_unit;
    import mc_ctrl_pkg::*;

`ifdef MCU_EXT_OPS_EN
    localparam bit EXT = 1'b1;
`else
    localparam bit EXT = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] st;
        logic       iord;
        logic       memWrite;
        logic       irWrite;
        logic       regDst;
        logic       memtoReg;
        logic       regWrite;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [2:0] aluCtrl;
        logic [1:0] pcSrc;
        logic       pcEn;
        logic       extZero;
        logic       illegalOp;
    } expT;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       iord, mem_write, ir_write, reg_dst, memto_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_control;
    logic       pc_en, ext_zero, illegal_op;
    logic [3:0] state_o;

    expT   expQ[$];
    string tagQ[$];
    int    errors = 0;
    int    checks = 0;
    string curName = "reset";

    multicycle_control_unit dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .memto_reg(memto_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
        .pc_src(pc_src), .pc_en(pc_en), .ext_zero(ext_zero), .illegal_op(illegal_op),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    // Which opcodes this build is meant to execute
    function automatic bit legal(input logic [5:0] op);
        if (op == OP_LW || op == OP_SW || op == OP_RTYPE || op == OP_BEQ || op == OP_ADDI || op == OP_J)
            return 1'b1;
        if (EXT && (op == OP_BNE || op == OP_ANDI || op == OP_ORI))
            return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [2:0] fnAlu(input logic [5:0] fn);
        if (fn == FN_ADD) return 3'b010;
        if (fn == FN_SUB) return 3'b110;
        if (fn == FN_AND) return 3'b000;
        if (fn == FN_OR)  return 3'b001;
        if (fn == FN_SLT) return 3'b111;
        return 3'b010;
    endfunction

    // Expected outputs for one cycle, straight from the per-state output table
    function automatic expT refModel(input state_t s, input logic [5:0] op, input logic [5:0] fn,
                                     input logic z, input logic mr);
        expT e;
        e    = '0;
        e.st = s;
        case (s)
            FETCH:   begin e.aluSrcB = 2'b01; e.aluCtrl = 3'b010; e.irWrite = mr; e.pcEn = mr; end
            DECODE:  begin e.aluSrcB = 2'b11; e.aluCtrl = 3'b010; e.illegalOp = !legal(op); end
            MEMADR:  begin e.aluSrcA = 1; e.aluSrcB = 2'b10; e.aluCtrl = 3'b010; end
            MEMRD:   e.iord = 1;
            MEMWB:   begin e.regWrite = 1; e.memtoReg = 1; end
            MEMWR:   begin e.iord = 1; e.memWrite = 1; end
            EXECUTE: begin e.aluSrcA = 1; e.aluCtrl = fnAlu(fn); end
            ALUWB:   begin e.regWrite = 1; e.regDst = 1; end
            BRANCH:  begin
                e.aluSrcA = 1; e.aluCtrl = 3'b110; e.pcSrc = 2'b01;
                e.pcEn = (op == OP_BNE) ? !z : z;
            end
            ADDIEX:  begin e.aluSrcA = 1; e.aluSrcB = 2'b10; e.aluCtrl = 3'b010; end
            ADDIWB:  e.regWrite = 1;
            JUMP:    begin e.pcSrc = 2'b10; e.pcEn = 1; end
            IMMEX:   begin
                e.aluSrcA = 1; e.aluSrcB = 2'b10; e.extZero = 1;
                e.aluCtrl = (op == OP_ORI) ? 3'b001 : 3'b000;
            end
            default: ;
        endcase
        return e;
    endfunction

    // Drive one cycle's inputs right after the rising edge and queue that cycle's expectation
    task automatic step(input state_t st, input logic mr, input logic z, input logic rv);
        rst_n     = rv;
        mem_ready = mr;
        zero      = z;
        expQ.push_back(rv ? refModel(st, opcode, funct, z, mr) : expT'(0));
        tagQ.push_back($sformatf("%s@%s", curName, rv ? st.name() : "RESET"));
        @(posedge clk);
        #1;
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // One whole instruction: FETCH stalls, decode, then the class-specific states
    task automatic applyStimulus(input string name, input logic [5:0] op, input logic [5:0] fn,
                                 input logic zb, input int fetchStall, input int memStall);
        curName = name;
        opcode  = op;
        funct   = fn;
        for (int i = 0; i < fetchStall; i++) step(FETCH, 1'b0, rb(), 1'b1);
        step(FETCH, 1'b1, rb(), 1'b1);
        step(DECODE, rb(), rb(), 1'b1);
        if (!legal(op)) return;
        if (op == OP_LW) begin
            step(MEMADR, rb(), rb(), 1'b1);
            for (int i = 0; i < memStall; i++) step(MEMRD, 1'b0, rb(), 1'b1);
            step(MEMRD, 1'b1, rb(), 1'b1);
            step(MEMWB, rb(), rb(), 1'b1);
        end else if (op == OP_SW) begin
            step(MEMADR, rb(), rb(), 1'b1);
            for (int i = 0; i < memStall; i++) step(MEMWR, 1'b0, rb(), 1'b1);
            step(MEMWR, 1'b1, rb(), 1'b1);
        end else if (op == OP_RTYPE) begin
            step(EXECUTE, rb(), rb(), 1'b1);
            step(ALUWB, rb(), rb(), 1'b1);
        end else if (op == OP_BEQ || op == OP_BNE) begin
            step(BRANCH, rb(), zb, 1'b1);
        end else if (op == OP_ADDI) begin
            step(ADDIEX, rb(), rb(), 1'b1);
            step(ADDIWB, rb(), rb(), 1'b1);
        end else if (op == OP_ANDI || op == OP_ORI) begin
            step(IMMEX, rb(), rb(), 1'b1);
            step(ADDIWB, rb(), rb(), 1'b1);
        end else begin
            step(JUMP, rb(), rb(), 1'b1);
        end
    endtask

    task automatic checkOutput(input expT e, input string tag);
        expT act;
        act = '{st: state_o, iord: iord, memWrite: mem_write, irWrite: ir_write, regDst: reg_dst,
                memtoReg: memto_reg, regWrite: reg_write, aluSrcA: alu_src_a, aluSrcB: alu_src_b,
                aluCtrl: alu_control, pcSrc: pc_src, pcEn: pc_en, extZero: ext_zero,
                illegalOp: illegal_op};
        checks++;
        if (act !== e) begin
            errors++;
            $display("[TB] FAIL %s: actual=%b required=%b (st,iord,mw,irw,rdst,m2r,rw,sa,sb,alu,pcs,pce,ez,ill)",
                     tag, act, e);
        end
    endtask

    // Monitor: the DUT presents a control word every cycle, compared mid-cycle
    initial begin
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) checkOutput(expQ.pop_front(), tagQ.pop_front());
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    logic [5:0] opList[9];
    logic [5:0] fnList[6];

    initial begin
        opList = '{OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J, OP_BNE, OP_ANDI, OP_ORI};
        fnList = '{FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, 6'b000000};

        @(posedge clk);
        #1;
        step(FETCH, 1'b1, 1'b0, 1'b0);
        step(FETCH, 1'b1, 1'b0, 1'b0);

        applyStimulus("lw", OP_LW, FN_ADD, 1'b0, 0, 0);
        applyStimulus("add", OP_RTYPE, FN_ADD, 1'b0, 0, 0);
        applyStimulus("beqTaken", OP_BEQ, 6'd0, 1'b1, 0, 0);
        applyStimulus("beqNotTaken", OP_BEQ, 6'd0, 1'b0, 0, 0);
        applyStimulus("swStall", OP_SW, 6'd0, 1'b0, 3, 3);
        applyStimulus("lwStall", OP_LW, 6'd0, 1'b0, 2, 3);
        applyStimulus("illegal", 6'b111111, 6'd0, 1'b0, 0, 0);
        applyStimulus("ori", OP_ORI, 6'd0, 1'b0, 0, 0);
        applyStimulus("andi", OP_ANDI, 6'd0, 1'b0, 0, 0);
        applyStimulus("bneZero0", OP_BNE, 6'd0, 1'b0, 0, 0);
        applyStimulus("bneZero1", OP_BNE, 6'd0, 1'b1, 0, 0);
        applyStimulus("j", OP_J, 6'd0, 1'b0, 0, 0);
        applyStimulus("addi", OP_ADDI, 6'd0, 1'b0, 0, 0);
        applyStimulus("rUnknownFn", OP_RTYPE, 6'b111000, 1'b0, 0, 0);
        applyStimulus("slt", OP_RTYPE, FN_SLT, 1'b0, 0, 0);

        curName = "lwReset";
        opcode  = OP_LW;
        step(FETCH, 1'b1, 1'b0, 1'b1);
        step(DECODE, 1'b1, 1'b0, 1'b1);
        step(MEMADR, 1'b1, 1'b0, 1'b1);
        step(MEMRD, 1'b0, 1'b0, 1'b1);
        step(MEMRD, 1'b1, 1'b0, 1'b0);
        step(FETCH, 1'b1, 1'b0, 1'b0);
        applyStimulus("lwAfterReset", OP_LW, 6'd0, 1'b0, 0, 0);

        for (int n = 0; n < 80; n++) begin
            logic [5:0] op, fn;
            op = ($urandom_range(0, 9) == 9) ? 6'($urandom_range(0, 63)) : opList[$urandom_range(0, 8)];
            fn = ($urandom_range(0, 5) == 5) ? 6'($urandom_range(0, 63)) : fnList[$urandom_range(0, 4)];
            applyStimulus($sformatf("rand%0d", n), op, fn, rb(),
                          $urandom_range(0, 2), $urandom_range(0, 3));
        end

        @(negedge clk);
        #1;
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: actual=%0d pending required=0", expQ.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
